// File: rtl/perceptron_pkg.sv
// Shared widths and signed-range helpers for the saturating accumulator slice.
package perceptron_pkg;

   localparam int DEF_AW = 4;
   localparam int DEF_BW = 2;

   // Largest and smallest values representable in a w-bit two's-complement word.
   function automatic int smax(input int unsigned w);
      return (1 <<< (w - 1)) - 1;
   endfunction

   function automatic int smin(input int unsigned w);
      return -(1 <<< (w - 1));
   endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational signed add of a BW-bit sample into an AW-bit accumulator,
// with either clamping or wrap-around and an out-of-range flag.
module sat_add
   import perceptron_pkg::*;
#(
   parameter int AW       = DEF_AW,
   parameter int BW       = DEF_BW,
   parameter int SATURATE = 1
) (
   input  logic [AW-1:0] a,
   input  logic [BW-1:0] b,
   output logic [AW-1:0] sum,
   output logic          ovf
);

   typedef logic signed [AW:0] ext_t;

   localparam ext_t MAX_V = ext_t'(smax(AW));
   localparam ext_t MIN_V = ext_t'(smin(AW));

   ext_t exact;

   // One guard bit is enough: |a + b| never exceeds twice the AW-bit range.
   always_comb begin
      exact = ext_t'($signed(a)) + ext_t'($signed(b));
      ovf   = (exact > MAX_V) || (exact < MIN_V);
      sum   = exact[AW-1:0];
      if (SATURATE != 0) begin
         if (exact > MAX_V)
            sum = MAX_V[AW-1:0];
         else if (exact < MIN_V)
            sum = MIN_V[AW-1:0];
      end
   end

endmodule

// File: rtl/sat_accum.sv
// Burst accumulator: sums LEN accepted signed samples, then reports the total
// and a sticky overflow flag with a one-cycle out_valid pulse.
module sat_accum
   import perceptron_pkg::*;
#(
   parameter int AW       = DEF_AW,
   parameter int BW       = DEF_BW,
   parameter int LEN      = 8,
   parameter int SATURATE = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          in_valid,
   input  logic [BW-1:0] in_data,
   output logic [AW-1:0] acc,
   output logic          out_valid,
   output logic [AW-1:0] out_sum,
   output logic          out_ovf
);

   localparam int            CW   = (LEN > 1) ? $clog2(LEN) : 1;
   localparam logic [CW-1:0] LAST = CW'(LEN - 1);

   logic [CW-1:0] cnt;
   logic          sticky;
   logic [AW-1:0] nsum;
   logic          novf;

   sat_add #(
      .AW       (AW),
      .BW       (BW),
      .SATURATE (SATURATE)
   ) u_sat_add (
      .a   (acc),
      .b   (in_data),
      .sum (nsum),
      .ovf (novf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         cnt       <= '0;
         sticky    <= 1'b0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_ovf   <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         // clear wins over a same-cycle sample, including a burst-final one
         if (clear) begin
            acc    <= '0;
            cnt    <= '0;
            sticky <= 1'b0;
         end else if (in_valid) begin
            if (cnt == LAST) begin
               out_valid <= 1'b1;
               out_sum   <= nsum;
               out_ovf   <= sticky | novf;
               acc       <= '0;
               cnt       <= '0;
               sticky    <= 1'b0;
            end else begin
               acc    <= nsum;
               cnt    <= cnt + 1'b1;
               sticky <= sticky | novf;
            end
         end
      end
   end

endmodule

// File: tb/tb_sat_accum.sv
// Directed bench for sat_accum: saturating, wrapping and single-sample-burst
// instances share one stimulus stream.
module tb_sat_accum;

   logic       clk;
   logic       rst_n;
   logic       clear;
   logic       in_valid;
   logic [1:0] in_data;

   logic [3:0] s_acc, s_sum, w_acc, w_sum, l_acc, l_sum;
   logic       s_ov, s_ovf, w_ov, w_ovf, l_ov, l_ovf;

   int n_chk = 0;
   int n_err = 0;

   sat_accum #(.AW(4), .BW(2), .LEN(8), .SATURATE(1)) u_sat (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
      .acc(s_acc), .out_valid(s_ov), .out_sum(s_sum), .out_ovf(s_ovf)
   );

   sat_accum #(.AW(4), .BW(2), .LEN(8), .SATURATE(0)) u_wrap (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
      .acc(w_acc), .out_valid(w_ov), .out_sum(w_sum), .out_ovf(w_ovf)
   );

   sat_accum #(.AW(4), .BW(2), .LEN(1), .SATURATE(1)) u_len1 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
      .acc(l_acc), .out_valid(l_ov), .out_sum(l_sum), .out_ovf(l_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       clr;
      logic       vld;
      logic [1:0] din;
      logic [3:0] acc;
      logic       ov;
      logic [3:0] sum;
      logic       ovf;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, then sample just after the rising edge.
   task automatic cyc(input logic c, input logic v, input logic [1:0] d);
      clear    = c;
      in_valid = v;
      in_data  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_sat(input string nm, input logic [3:0] a, input logic ov,
                          input logic [3:0] sm, input logic of);
      chk({nm, ".acc"}, s_acc, a);
      chk({nm, ".out_valid"}, s_ov, ov);
      chk({nm, ".out_sum"}, s_sum, sm);
      chk({nm, ".out_ovf"}, s_ovf, of);
   endtask

   initial begin
      rst_n    = 1'b1;
      clear    = 1'b0;
      in_valid = 1'b0;
      in_data  = 2'b00;

      // Asynchronous reset before any clock edge.
      #1 rst_n = 1'b0;
      #1;
      chk_sat("rst0", 4'h0, 1'b0, 4'h0, 1'b0);
      chk("rst0.w_sum", w_sum, 4'h0);
      chk("rst0.l_ov", l_ov, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // +1 x8 saturating, then -2 x8 back-to-back, then a mixed burst with a gap.
      for (int i = 1; i <= 7; i++)
         tbl.push_back('{1'b0, 1'b1, 2'b01, 4'(i), 1'b0, 4'h0, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 2'b01, 4'h0, 1'b1, 4'h7, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 2'b10, 4'hE, 1'b0, 4'h7, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 2'b10, 4'hC, 1'b0, 4'h7, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 2'b10, 4'hA, 1'b0, 4'h7, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 2'b10, 4'h8, 1'b0, 4'h7, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 2'b10, 4'h8, 1'b0, 4'h7, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 2'b10, 4'h8, 1'b0, 4'h7, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 2'b10, 4'h8, 1'b0, 4'h7, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 2'b10, 4'h0, 1'b1, 4'h8, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 2'b00, 4'h0, 1'b0, 4'h8, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 2'b01, 4'h1, 1'b0, 4'h8, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 2'b01, 4'h2, 1'b0, 4'h8, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 2'b11, 4'h1, 1'b0, 4'h8, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 2'b10, 4'hF, 1'b0, 4'h8, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 2'b01, 4'hF, 1'b0, 4'h8, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 2'b01, 4'h0, 1'b0, 4'h8, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 2'b01, 4'h1, 1'b0, 4'h8, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 2'b11, 4'h0, 1'b0, 4'h8, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 2'b01, 4'h0, 1'b1, 4'h1, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 2'b00, 4'h0, 1'b0, 4'h1, 1'b0});

      foreach (tbl[i]) begin
         cyc(tbl[i].clr, tbl[i].vld, tbl[i].din);
         chk_sat($sformatf("vec%0d", i), tbl[i].acc, tbl[i].ov, tbl[i].sum, tbl[i].ovf);
      end

      // clear together with sample 5: sample dropped, out_sum kept, fresh 8 needed.
      for (int i = 1; i <= 4; i++) cyc(1'b0, 1'b1, 2'b01);
      chk("clr5.pre_acc", s_acc, 4'h4);
      cyc(1'b1, 1'b1, 2'b01);
      chk_sat("clr5", 4'h0, 1'b0, 4'h1, 1'b0);
      for (int i = 1; i <= 7; i++) begin
         cyc(1'b0, 1'b1, 2'b01);
         chk($sformatf("clr5.refill%0d.ov", i), s_ov, 1'b0);
      end
      chk("clr5.refill_acc", s_acc, 4'h7);
      cyc(1'b0, 1'b1, 2'b11);
      chk_sat("clr5.done", 4'h0, 1'b1, 4'h6, 1'b0);

      // Alternating +1/-1 with random idle gaps.
      begin
         int got   = 0;
         int acc_m = 0;
         int ncyc  = 0;
         logic v;
         logic [1:0] d;
         while (got < 8 && ncyc < 64) begin
            v = ($urandom_range(0, 2) != 0);
            d = (got % 2 == 0) ? 2'b01 : 2'b11;
            cyc(1'b0, v, d);
            ncyc++;
            if (v) begin
               got++;
               acc_m += (d == 2'b01) ? 1 : -1;
            end
            if (got < 8) begin
               chk($sformatf("alt.c%0d.acc", ncyc), s_acc, 4'(acc_m));
               chk($sformatf("alt.c%0d.ov", ncyc), s_ov, 1'b0);
            end
         end
         if (got < 8) begin
            n_chk++;
            n_err++;
            $display("FAIL alt.timeout: got %0d accepted samples, expected 8", got);
         end else begin
            chk_sat("alt.done", 4'h0, 1'b1, 4'h0, 1'b0);
            cyc(1'b0, 1'b0, 2'b00);
            chk("alt.pulse_width", s_ov, 1'b0);
         end
      end

      // clear on the final sample discards the whole burst.
      for (int i = 1; i <= 7; i++) cyc(1'b0, 1'b1, 2'b01);
      cyc(1'b1, 1'b1, 2'b01);
      chk_sat("clr_last", 4'h0, 1'b0, 4'h0, 1'b0);
      cyc(1'b0, 1'b0, 2'b00);
      chk("clr_last.late_ov", s_ov, 1'b0);

      // Full burst to load a nonzero result, then reset mid-burst.
      for (int i = 1; i <= 8; i++) cyc(1'b0, 1'b1, 2'b01);
      chk_sat("pre_rst", 4'h0, 1'b1, 4'h7, 1'b1);
      for (int i = 1; i <= 3; i++) cyc(1'b0, 1'b1, 2'b01);
      chk("pre_rst.acc", s_acc, 4'h3);
      cyc(1'b0, 1'b0, 2'b00);
      #2 rst_n = 1'b0;
      #1;
      chk_sat("mid_rst", 4'h0, 1'b0, 4'h0, 1'b0);
      chk("mid_rst.w_acc", w_acc, 4'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // After reset: +1 x8 on both saturating and wrapping instances.
      for (int i = 1; i <= 7; i++) begin
         cyc(1'b0, 1'b1, 2'b01);
         chk($sformatf("post_rst%0d.acc", i), s_acc, 4'(i));
         chk($sformatf("post_rst%0d.w_acc", i), w_acc, 4'(i));
         chk($sformatf("post_rst%0d.ov", i), s_ov, 1'b0);
      end
      cyc(1'b0, 1'b1, 2'b01);
      chk_sat("post_rst.done", 4'h0, 1'b1, 4'h7, 1'b1);
      chk("wrap.out_valid", w_ov, 1'b1);
      chk("wrap.out_sum", w_sum, 4'h8);
      chk("wrap.out_ovf", w_ovf, 1'b1);
      chk("wrap.acc", w_acc, 4'h0);

      // LEN=1: every accepted sample is its own burst.
      cyc(1'b0, 1'b1, 2'b01);
      chk("len1.a.ov", l_ov, 1'b1);
      chk("len1.a.sum", l_sum, 4'h1);
      chk("len1.a.ovf", l_ovf, 1'b0);
      chk("len1.a.acc", l_acc, 4'h0);
      cyc(1'b0, 1'b0, 2'b00);
      chk("len1.idle.ov", l_ov, 1'b0);
      chk("len1.idle.sum", l_sum, 4'h1);
      cyc(1'b0, 1'b1, 2'b10);
      chk("len1.b.ov", l_ov, 1'b1);
      chk("len1.b.sum", l_sum, 4'hE);
      cyc(1'b1, 1'b1, 2'b01);
      chk("len1.clr.ov", l_ov, 1'b0);
      chk("len1.clr.sum", l_sum, 4'hE);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
